// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the row-scanned PWM matrix driver family.
// Top levels reuse the DEF_* values so that every instance agrees on the default geometry.
package matrix_pkg;

  localparam int unsigned DEF_ROWS     = 8;
  localparam int unsigned DEF_COLS     = 8;
  localparam int unsigned DEF_PWM_BITS = 4;
  localparam int unsigned DEF_PRESCALE = 65536;

  // Slot 0 of every row is dark so the row switch never ghosts into its neighbour.
  localparam int unsigned BLANK_SLOT = 0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Highest intensity code, which is also the last PWM slot index.
  function automatic int unsigned max_level(input int unsigned pwm_bits);
    return (32'd1 << pwm_bits) - 1;
  endfunction

endpackage

// File: rtl/matrix_dbuf.sv
// Double-buffered frame store: host writes land in the back bank, the scanner reads one row
// of the front bank combinationally, and a swap only flips the bank select.
module matrix_dbuf
  import matrix_pkg::*;
#(
  parameter  int unsigned ROWS     = DEF_ROWS,
  parameter  int unsigned COLS     = DEF_COLS,
  parameter  int unsigned PWM_BITS = DEF_PWM_BITS,
  localparam int unsigned DEPTH    = ROWS * COLS,
  localparam int unsigned AW       = clog2(DEPTH),
  localparam int unsigned RW       = clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [PWM_BITS-1:0]      wr_data_i,
  input  logic                     swap_i,
  input  logic [RW-1:0]            rd_row_i,
  output logic [COLS*PWM_BITS-1:0] rd_data_o
);

  logic                sel_q;
  logic [PWM_BITS-1:0] bank0_q [DEPTH];
  logic [PWM_BITS-1:0] bank1_q [DEPTH];
  logic                wr_ok;
  logic [AW-1:0]       rd_idx;

  assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < (AW+1)'(DEPTH));

  // NOTE: both banks are reset because a freshly reset display must show an all-dark frame;
  // this forces flip-flop storage instead of a RAM macro, acceptable at these matrix sizes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments here let the write and the sel toggle sample the same
      // pre-edge sel_q, so a write on the swap cycle lands in the bank that becomes front.
      if (wr_ok) begin
        if (sel_q) bank0_q[wr_addr_i] <= wr_data_i;
        else       bank1_q[wr_addr_i] <= wr_data_i;
      end
      if (swap_i) sel_q <= ~sel_q;
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    rd_data_o = '0;
    rd_idx    = '0;
    for (int c = 0; c < COLS; c++) begin
      rd_idx = AW'(int'(rd_row_i) * COLS + c);
      rd_data_o[c*PWM_BITS +: PWM_BITS] = sel_q ? bank1_q[rd_idx] : bank0_q[rd_idx];
    end
  end

endmodule

// File: rtl/matrix_pwm_drv.sv
// Row-scanned LED matrix driver: prescaler, PWM slot and row counters, swap handshake and
// registered row/column drive, reading pixel intensities from the matrix_dbuf front bank.
module matrix_pwm_drv
  import matrix_pkg::*;
#(
  parameter  int unsigned ROWS           = DEF_ROWS,
  parameter  int unsigned COLS           = DEF_COLS,
  parameter  int unsigned PWM_BITS       = DEF_PWM_BITS,
  parameter  int unsigned PRESCALE       = DEF_PRESCALE,
  parameter  bit          ROW_ACTIVE_LOW = 1'b0,
  parameter  bit          COL_ACTIVE_LOW = 1'b0,
  localparam int unsigned AW             = clog2(ROWS * COLS)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [PWM_BITS-1:0] wr_data,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                frame_start,
  output logic [ROWS-1:0]     rows,
  output logic [COLS-1:0]     columns
);

  localparam int unsigned         RW         = clog2(ROWS);
  localparam int unsigned         PS_W       = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [RW-1:0]       ROW_LAST   = RW'(ROWS - 1);
  localparam logic [PWM_BITS-1:0] SLOT_LAST  = PWM_BITS'(max_level(PWM_BITS));
  localparam logic [PWM_BITS-1:0] SLOT_BLANK = PWM_BITS'(BLANK_SLOT);
  localparam logic [ROWS-1:0]     ROW_MASK   = {ROWS{ROW_ACTIVE_LOW}};
  localparam logic [COLS-1:0]     COL_MASK   = {COLS{COL_ACTIVE_LOW}};

  logic [PS_W-1:0]          presc_q, presc_d;
  logic [PWM_BITS-1:0]      slot_q, slot_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     pending_q, pending_d;
  logic [ROWS-1:0]          rows_q, rows_d;
  logic [COLS-1:0]          cols_q, cols_d;
  logic                     tick, boundary, do_swap;
  logic [ROWS-1:0]          row_on;
  logic [COLS-1:0]          col_on;
  logic [COLS*PWM_BITS-1:0] row_data;

  matrix_dbuf #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .PWM_BITS (PWM_BITS)
  ) u_dbuf (
    .clk       (CLK),
    .rst_n     (nRST),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .swap_i    (do_swap),
    .rd_row_i  (row_q),
    .rd_data_o (row_data)
  );

  assign tick     = (presc_q == PS_LAST);
  assign boundary = tick && (row_q == ROW_LAST) && (slot_q == SLOT_LAST);
  // A request arriving on the boundary tick itself is folded in rather than deferred a frame.
  assign do_swap  = boundary && (pending_q || swap_req);

  // The pulses mark the boundary cycle itself, so they are decoded straight from the counters.
  assign swap_ack    = do_swap;
  assign frame_start = boundary;
  assign rows        = rows_q;
  assign columns     = cols_q;

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    slot_d    = slot_q;
    row_d     = row_q;
    pending_d = do_swap ? 1'b0 : (pending_q || swap_req);
    row_on    = '0;
    col_on    = '0;
    if (tick) begin
      slot_d = slot_q + 1'b1;
      if (slot_q == SLOT_LAST) row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
    if (slot_q != SLOT_BLANK) begin
      row_on[row_q] = 1'b1;
      for (int c = 0; c < COLS; c++) begin
        col_on[c] = (row_data[c*PWM_BITS +: PWM_BITS] >= slot_q);
      end
    end
    rows_d = row_on ^ ROW_MASK;
    cols_d = col_on ^ COL_MASK;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      presc_q   <= '0;
      slot_q    <= '0;
      row_q     <= '0;
      pending_q <= 1'b0;
      rows_q    <= ROW_MASK;
      cols_q    <= COL_MASK;
    end else begin
      presc_q   <= presc_d;
      slot_q    <= slot_d;
      row_q     <= row_d;
      pending_q <= pending_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
    end
  end

endmodule

// File: tb/tb_matrix_pwm_drv.sv
// Randomised self-checking bench for matrix_pwm_drv against a frame-position reference model
// (8x8 matrix, 2-bit intensity, one clock per PWM slot).
module tb_matrix_pwm_drv;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int PWM_BITS = 2;
  localparam int PRESCALE = 1;
  localparam int SLOTS    = 1 << PWM_BITS;
  localparam int FRAME    = ROWS * SLOTS * PRESCALE;
  localparam int NPIX     = ROWS * COLS;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [1:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       swap_ack, frame_start;
  logic [7:0] rows, columns;

  matrix_pwm_drv #(
    .ROWS           (ROWS),
    .COLS           (COLS),
    .PWM_BITS       (PWM_BITS),
    .PRESCALE       (PRESCALE),
    .ROW_ACTIVE_LOW (1'b0),
    .COL_ACTIVE_LOW (1'b0)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_start (frame_start),
    .rows        (rows),
    .columns     (columns)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: cycle position inside the frame plus two pixel arrays.
  int         front [NPIX];
  int         back  [NPIX];
  int         pos;
  bit         pending;
  logic [7:0] exp_rows, exp_cols;

  logic       obs_fs, obs_ack;
  logic [7:0] obs_rows, obs_cols;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    pos      = 0;
    pending  = 1'b0;
    exp_rows = '0;
    exp_cols = '0;
    for (int i = 0; i < NPIX; i++) begin
      front[i] = 0;
      back[i]  = 0;
    end
  endtask

  // One clock: drive inputs, compare all outputs for this cycle, then advance the model.
  task automatic step(input bit we, input int addr, input int data, input bit sr);
    bit exp_fs, exp_ack;
    int slot, row, tmp;
    @(negedge CLK);
    wr_en    = we;
    wr_addr  = addr[5:0];
    wr_data  = data[1:0];
    swap_req = sr;
    #1;
    exp_fs   = (pos == FRAME - 1);
    exp_ack  = exp_fs && (pending || sr);
    obs_fs   = frame_start;
    obs_ack  = swap_ack;
    obs_rows = rows;
    obs_cols = columns;
    check("frame_start", obs_fs, exp_fs);
    check("swap_ack", obs_ack, exp_ack);
    check("rows", obs_rows, exp_rows);
    check("columns", obs_cols, exp_cols);
    @(posedge CLK);
    slot = (pos / PRESCALE) % SLOTS;
    row  = pos / (PRESCALE * SLOTS);
    exp_rows = '0;
    exp_cols = '0;
    if (slot != 0) begin
      exp_rows[row] = 1'b1;
      for (int c = 0; c < COLS; c++) exp_cols[c] = (front[row*COLS + c] >= slot);
    end
    if (we && addr < NPIX) back[addr] = data;
    if (exp_ack) begin
      for (int i = 0; i < NPIX; i++) begin
        tmp      = front[i];
        front[i] = back[i];
        back[i]  = tmp;
      end
      pending = 1'b0;
    end else if (sr) begin
      pending = 1'b1;
    end
    pos = (pos + 1) % FRAME;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  // Assert reset mid-cycle, check the asynchronous inactive state while held, then release.
  task automatic hold_reset(input int cycles);
    @(posedge CLK);
    #3;
    nRST     = 1'b0;
    wr_en    = 1'b0;
    swap_req = 1'b0;
    #1;
    check("rst_async_rows", rows, 8'h00);
    check("rst_async_cols", columns, 8'h00);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      #1;
      check("rst_rows", rows, 8'h00);
      check("rst_cols", columns, 8'h00);
      check("rst_frame_start", frame_start, 1'b0);
      check("rst_swap_ack", swap_ack, 1'b0);
    end
    @(posedge CLK);
    #2;
    nRST = 1'b1;
    model_reset();
  endtask

  // Step until the next frame_start; the following step is cycle 1 of a frame.
  task automatic align_frame();
    int n;
    n = 0;
    do begin
      step(1'b0, 0, 0, 1'b0);
      n++;
    end while (!obs_fs && n < FRAME + 2);
    check("align_frame_seen", obs_fs, 1'b1);
  endtask

  int first_fs, n, lat, acks;
  int lit [4];
  int blank_rows, blank_cols;

  initial begin
    model_reset();
    hold_reset(4);

    // First frame boundary after reset release.
    first_fs = 0;
    for (int i = 1; i <= FRAME + 8; i++) begin
      step(1'b0, 0, 0, 1'b0);
      if (obs_fs && first_fs == 0) first_fs = i;
    end
    check("first_frame_start_cycle", first_fs, FRAME);

    // PWM levels: intensities 0..3 on pixels 0..3, swapped to front.
    for (int p = 0; p < 4; p++) step(1'b1, p, p, 1'b0);
    step(1'b0, 0, 0, 1'b1);
    n = 0;
    while (!obs_ack && n < FRAME + 2) begin
      step(1'b0, 0, 0, 1'b0);
      n++;
    end
    check("pwm_swap_ack_seen", obs_ack, 1'b1);
    for (int c = 0; c < 4; c++) lit[c] = 0;
    blank_rows = 0;
    blank_cols = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 0, 0, 1'b0);
      if (obs_rows == 8'h01)
        for (int c = 0; c < 4; c++) lit[c] += int'(obs_cols[c]);
      if (obs_rows == 8'h00) begin
        blank_rows++;
        if (obs_cols == 8'h00) blank_cols++;
      end
    end
    for (int c = 0; c < 4; c++) check($sformatf("pwm_lit_col%0d", c), lit[c], c);
    check("pwm_blank_slots", blank_rows, ROWS);
    check("pwm_blank_cols", blank_cols, ROWS);

    // Swap timing: request on cycle 5 of a frame, ack must land on the next boundary.
    step(1'b1, 8, 3, 1'b0);
    align_frame();
    idle(4);
    step(1'b0, 0, 0, 1'b1);
    lat = 0;
    do begin
      step(1'b0, 0, 0, 1'b0);
      lat++;
    end while (!obs_ack && lat < FRAME + 2);
    check("swap_latency", lat, FRAME - 5);
    check("swap_ack_with_frame_start", obs_fs, 1'b1);
    idle(FRAME);

    // Merged requests: three pulses in one frame give one swap.
    align_frame();
    acks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 0, 0, (i == 2 || i == 10 || i == 20));
      acks += int'(obs_ack);
    end
    check("merged_swap_count", acks, 1);

    // Boundary collision: write + request on the boundary cycle itself.
    n = 0;
    while (pos != FRAME - 1 && n < FRAME) begin
      step(1'b0, 0, 0, 1'b0);
      n++;
    end
    step(1'b1, 13, 2, 1'b1);
    check("collision_swap_ack", obs_ack, 1'b1);
    lit[0] = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 0, 0, 1'b0);
      if (obs_rows == 8'h02) lit[0] += int'(obs_cols[5]);
    end
    check("collision_pixel_lit", lit[0], 2);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, NPIX - 1)),
           int'($urandom_range(0, SLOTS - 1)), ($urandom_range(0, 39) == 0));
    end

    // Mid-frame reset with a swap pending: swap discarded, display dark.
    n = 0;
    while (pos != 2 && n < FRAME) begin
      step(1'b0, 0, 0, 1'b0);
      n++;
    end
    step(1'b0, 0, 0, 1'b1);
    n = 0;
    while (pos != 5 * SLOTS + 1 && n < FRAME) begin
      step(1'b0, 0, 0, 1'b0);
      n++;
    end
    hold_reset(3);
    acks = 0;
    lit[0] = 0;
    for (int i = 0; i < FRAME + 8; i++) begin
      step(1'b0, 0, 0, 1'b0);
      acks += int'(obs_ack);
      lit[0] += int'(obs_cols != 8'h00);
    end
    check("post_reset_swap_acks", acks, 0);
    check("post_reset_lit_cycles", lit[0], 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
